// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetches sequential instruction words, PC-tags them and queues them for decode
// Optional same-cycle decode bypass of an empty queue: IFQ_BYPASS_EN.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    output logic                     next_instr,
    input  logic [31:0]              instr,
    input  logic                     instr_valid,
    output logic [31:0]              dec_instr,
    output logic [31:0]              dec_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     fetch_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pending;
    logic [31:0]   pc_next;
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];

    logic          empty;
    logic          full;
    logic          fifo_pop;
    logic          bypass_take;
    logic          push;
    logic          accept;
    logic          issue;
    logic [AW+1:0] in_flight;

    assign empty    = (q_count == '0);
    assign full     = (q_count == CW'(DEPTH));
    assign fifo_pop = !empty && dec_ready;

    // Conservative: counts queued, in-flight and just-issued words, ignores a same-cycle pop.
    assign in_flight = (AW+2)'(q_count) + (AW+2)'(pending) + (AW+2)'(next_instr);
    assign issue     = fetch_en && (in_flight < (AW+2)'(DEPTH));

    always_comb begin
        bypass_take = 1'b0;
        dec_valid   = !empty;
        dec_instr   = empty ? 32'h0 : mem_instr[rd_ptr];
        dec_pc      = empty ? pc_next : mem_pc[rd_ptr];
`ifdef IFQ_BYPASS_EN
        if (empty && instr_valid) begin
            bypass_take = dec_ready;
            dec_valid   = 1'b1;
            dec_instr   = instr;
        end
`endif
    end

    // A spurious word arriving at a full queue is dropped unless a pop frees the slot.
    assign push   = instr_valid && (!full || fifo_pop) && !bypass_take;
    assign accept = push || bypass_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_instr <= 1'b0;
            pending    <= 1'b0;
            pc_next    <= PC_RESET;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            fetch_err  <= 1'b0;
        end else begin
            next_instr <= issue;
            pending    <= next_instr;
            if (accept)
                pc_next <= pc_next + 32'd4;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (fifo_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !fifo_pop)
                q_count <= q_count + CW'(1);
            else if (!push && fifo_pop)
                q_count <= q_count - CW'(1);
            if (instr_valid && !pending)
                fetch_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= instr;
            mem_pc[wr_ptr]    <= pc_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

`ifdef IFQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic        next_instr;
    logic [31:0] instr = 32'h0;
    logic        instr_valid = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [2:0]  q_count;
    logic        fetch_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          widx     = 0;
    int          npop     = 0;
    logic [31:0] exp_pc   = 32'h0;
    logic        req_d    = 1'b0;
    logic        mem_auto = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(4), .PC_RESET(32'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .next_instr (next_instr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .dec_instr  (dec_instr),
        .dec_pc     (dec_pc),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .q_count    (q_count),
        .fetch_err  (fetch_err)
    );

    // Memory word i: addi x(i), x0, i  -> 0x00000013, 0x00100093, ...
    function automatic logic [31:0] word(input int i);
        logic [11:0] imm;
        logic [4:0]  rd;
        imm = 12'(i);
        rd  = 5'(i);
        return {imm, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score any pop, then play the 1-cycle-latency memory.
    task automatic step();
        #1;
        if (dec_valid && dec_ready) begin
            chk("pop_pc", dec_pc, exp_pc);
            chk("pop_instr", dec_instr, word(int'(exp_pc >> 2)));
            exp_pc = exp_pc + 32'd4;
            npop++;
        end
        @(posedge clk);
        #2;
        instr_valid = mem_auto && req_d;
        if (mem_auto && req_d) begin
            instr = word(widx);
            widx++;
        end
        req_d = next_instr;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset state, asserted before any clock edge
        #1 reset = 1'b1;
        #2;
        chk("rst_next_instr", 32'(next_instr), 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_q_count", 32'(q_count), 32'h0);
        chk("rst_fetch_err", 32'(fetch_err), 32'h0);
        step();
        step();

        // 1: streaming, one pulse per cycle, words in order
        reset = 1'b0;
        fetch_en = 1'b1;
        dec_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t1_pulse", 32'(next_instr), 32'h1);
        end
        chk("t1_words_popped", 32'(npop >= 8), 32'h1);

        // 2: decode stalled, queue fills to exactly DEPTH
        dec_ready = 1'b0;
        for (int i = 0; i < 10 && q_count != 3'd4; i++) step();
        chk("t2_full", 32'(q_count), 32'd4);
        step();
        chk("t2_full_hold", 32'(q_count), 32'd4);
        chk("t2_no_issue", 32'(next_instr), 32'h0);
        chk("t2_head_pc", dec_pc, exp_pc);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk("t2_after_pop", 32'(q_count), 32'd3);
        chk("t2_no_issue_yet", 32'(next_instr), 32'h0);
        step();
        chk("t2_refill_issue", 32'(next_instr), 32'h1);
        step();
        chk("t2_single_issue", 32'(next_instr), 32'h0);
        step();
        chk("t2_refull", 32'(q_count), 32'd4);
        chk("t2_refull_no_issue", 32'(next_instr), 32'h0);

        // 3: fetch_en dropped after a pulse, then resumed
        dec_ready = 1'b1;
        for (int i = 0; i < 6 && !next_instr; i++) step();
        chk("t3_pulse_seen", 32'(next_instr), 32'h1);
        fetch_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_no_pulse", 32'(next_instr), 32'h0);
        end
        chk("t3_drained", 32'(q_count), 32'h0);
        chk("t3_dec_valid_low", 32'(dec_valid), 32'h0);
        fetch_en = 1'b1;
        step();
        chk("t3_resume_pulse", 32'(next_instr), 32'h1);
        for (int i = 0; i < 6; i++) step();

        // 4: spurious response sets sticky fetch_err
        fetch_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        dec_ready = 1'b0;
        chk("t4_empty", 32'(q_count), 32'h0);
        chk("t4_err_clear", 32'(fetch_err), 32'h0);
        mem_auto = 1'b0;
        instr_valid = 1'b1;
        instr = 32'hDEAD_BEEF;
        step();
        chk("t4_err_set", 32'(fetch_err), 32'h1);
        chk("t4_captured", 32'(q_count), 32'h1);
        chk("t4_word", dec_instr, 32'hDEAD_BEEF);
        chk("t4_word_pc", dec_pc, exp_pc);
        for (int i = 0; i < 3; i++) step();
        chk("t4_err_sticky", 32'(fetch_err), 32'h1);
        mem_auto = 1'b1;

        // 5: async reset with q_count=3 and a request in flight
        fetch_en = 1'b1;
        for (int i = 0; i < 8 && q_count != 3'd3; i++) step();
        chk("t5_q3", 32'(q_count), 32'd3);
        reset = 1'b1;
        instr_valid = 1'b0;
        req_d = 1'b0;
        widx = 0;
        exp_pc = 32'h0;
        #1;
        chk("t5_next_instr", 32'(next_instr), 32'h0);
        chk("t5_dec_valid", 32'(dec_valid), 32'h0);
        chk("t5_dec_instr", dec_instr, 32'h0);
        chk("t5_dec_pc", dec_pc, 32'h0);
        chk("t5_q_count", 32'(q_count), 32'h0);
        chk("t5_fetch_err", 32'(fetch_err), 32'h0);
        step();

        // 6: first word after reset, decode latency from instr_valid
        reset = 1'b0;
        dec_ready = 1'b1;
        step();
        chk("t6_first_pulse", 32'(next_instr), 32'h1);
        chk("t6_idle_valid", 32'(dec_valid), 32'h0);
        step();
        chk("t6_valid_same_cycle", 32'(dec_valid), 32'(BYP));
        step();
        chk("t6_valid_next_cycle", 32'(dec_valid), 32'h1);
        chk("t6_first_pc", dec_pc, BYP ? 32'h4 : 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("t6_steady_q", 32'(q_count), 32'(!BYP));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
